axi4_lite_arbiter: RTL and testbench

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

---
 rtl/axi4_lite_arbiter_if.sv | 52 +++++
 rtl/axi4_lite_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite channel bundle shared by the upstream requesters and the
// downstream target. The master modport drives valids, the slave modport
// drives readies and responses.
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1
);
  logic [I-1:0]   awid;
  logic [A-1:0]   awaddr;
  logic [2:0]     awprot;
  logic           awvalid;
  logic           awready;

  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wvalid;
  logic           wready;

  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready;

  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic [2:0]     arprot;
  logic           arvalid;
  logic           arready;

  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready;

  modport master (
    output awid, awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arprot, arvalid, input arready,
    input  rid, rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arprot, arvalid, output arready,
    output rid, rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter onto one shared target. The write path
// (AW/W/B) and the read path (AR/R) have independent round-robin arbiters,
// each allowing a single outstanding transaction. Payload is muxed straight
// through from the granted port; only grant, state and handshake progress
// are registered.
module axi4_lite_arbiter #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 1
) (
  input logic  aclk,
  input logic  areset,
  axi4_if.slave  axi4_s [2],
  axi4_if.master axi4_m
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  w_state_t w_state;
  r_state_t r_state;
  logic     w_gnt, w_last, aw_done, w_done;
  logic     r_gnt, r_last;

  // Upstream signals gathered into arrays so they can be indexed by grant.
  logic [1:0]     aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [I-1:0]   aw_id   [2];
  logic [A-1:0]   aw_addr [2];
  logic [2:0]     aw_prot [2];
  logic [8*N-1:0] w_data  [2];
  logic [N-1:0]   w_strb  [2];
  logic [I-1:0]   ar_id   [2];
  logic [A-1:0]   ar_addr [2];
  logic [2:0]     ar_prot [2];

  logic [1:0] w_req, r_req, w_own, r_own;
  logic       aw_open, w_open, b_open, ar_open, r_open;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Round-robin pick: a lone requester wins; with both, the port not
  // granted last time wins.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  assign w_req = aw_valid | w_valid;
  assign r_req = ar_valid;

  assign w_own = w_gnt ? 2'b10 : 2'b01;
  assign r_own = r_gnt ? 2'b10 : 2'b01;

  // Each address/data channel closes as soon as its own handshake is done,
  // so a held upstream valid is never forwarded twice.
  assign aw_open = (w_state == W_XFER) && !aw_done;
  assign w_open  = (w_state == W_XFER) && !w_done;
  assign b_open  = (w_state == W_RESP);
  assign ar_open = (r_state == R_ADDR);
  assign r_open  = (r_state == R_DATA);

  assign axi4_m.awid    = aw_id[w_gnt];
  assign axi4_m.awaddr  = aw_addr[w_gnt];
  assign axi4_m.awprot  = aw_prot[w_gnt];
  assign axi4_m.awvalid = aw_open && aw_valid[w_gnt];
  assign axi4_m.wdata   = w_data[w_gnt];
  assign axi4_m.wstrb   = w_strb[w_gnt];
  assign axi4_m.wvalid  = w_open && w_valid[w_gnt];
  assign axi4_m.bready  = b_open && b_ready[w_gnt];
  assign axi4_m.arid    = ar_id[r_gnt];
  assign axi4_m.araddr  = ar_addr[r_gnt];
  assign axi4_m.arprot  = ar_prot[r_gnt];
  assign axi4_m.arvalid = ar_open && ar_valid[r_gnt];
  assign axi4_m.rready  = r_open && r_ready[r_gnt];

  assign aw_hs = axi4_m.awvalid && axi4_m.awready;
  assign w_hs  = axi4_m.wvalid  && axi4_m.wready;
  assign b_hs  = axi4_m.bvalid  && axi4_m.bready;
  assign ar_hs = axi4_m.arvalid && axi4_m.arready;
  assign r_hs  = axi4_m.rvalid  && axi4_m.rready;

  for (genvar k = 0; k < 2; k++) begin : g_port
    assign aw_valid[k] = axi4_s[k].awvalid;
    assign aw_id[k]    = axi4_s[k].awid;
    assign aw_addr[k]  = axi4_s[k].awaddr;
    assign aw_prot[k]  = axi4_s[k].awprot;
    assign w_valid[k]  = axi4_s[k].wvalid;
    assign w_data[k]   = axi4_s[k].wdata;
    assign w_strb[k]   = axi4_s[k].wstrb;
    assign b_ready[k]  = axi4_s[k].bready;
    assign ar_valid[k] = axi4_s[k].arvalid;
    assign ar_id[k]    = axi4_s[k].arid;
    assign ar_addr[k]  = axi4_s[k].araddr;
    assign ar_prot[k]  = axi4_s[k].arprot;
    assign r_ready[k]  = axi4_s[k].rready;

    // Readies and response valids reach the granted port only; responses
    // pass through unmodified.
    assign axi4_s[k].awready = w_own[k] && aw_open && axi4_m.awready;
    assign axi4_s[k].wready  = w_own[k] && w_open  && axi4_m.wready;
    assign axi4_s[k].bvalid  = w_own[k] && b_open  && axi4_m.bvalid;
    assign axi4_s[k].bresp   = axi4_m.bresp;
    assign axi4_s[k].bid     = axi4_m.bid;
    assign axi4_s[k].arready = r_own[k] && ar_open && axi4_m.arready;
    assign axi4_s[k].rvalid  = r_own[k] && r_open  && axi4_m.rvalid;
    assign axi4_s[k].rdata   = axi4_m.rdata;
    assign axi4_s[k].rresp   = axi4_m.rresp;
    assign axi4_s[k].rid     = axi4_m.rid;
  end

  // Write arbiter: grant, then AW and W in either order, then B.
  always_ff @(posedge aclk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // the sensitivity list carries only the clock.
    if (areset) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      w_last  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every branch below reads the
      // pre-edge flag values even where a flag is also updated.
      case (w_state)
        W_IDLE: if (|w_req) begin
          w_gnt   <= pick(w_req, w_last);
          w_last  <= pick(w_req, w_last);
          w_state <= W_XFER;
        end
        W_XFER: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done || aw_hs) && (w_done || w_hs)) w_state <= W_RESP;
        end
        W_RESP: if (b_hs) begin
          w_state <= W_IDLE;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read arbiter: grant, then AR, then R.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        R_IDLE: if (|r_req) begin
          r_gnt   <= pick(r_req, r_last);
          r_last  <= pick(r_req, r_last);
          r_state <= R_ADDR;
        end
        R_ADDR:  if (ar_hs) r_state <= R_DATA;
        R_DATA:  if (r_hs)  r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Scoreboard bench for axi4_lite_arbiter: directed stimulus pushes expected
// downstream AW/W beats and upstream B/R responses; negedge monitors pop and
// compare whenever a handshake is presented.
module tb_axi4_lite_arbiter;
  localparam int A = 32;
  localparam int N = 4;
  localparam int I = 1;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_if #(.A(A), .N(N), .I(I)) s_if [2] ();
  axi4_if #(.A(A), .N(N), .I(I)) m_if ();

  axi4_lite_arbiter #(.A(A), .N(N), .I(I)) dut (
    .aclk  (aclk),
    .areset(areset),
    .axi4_s(s_if),
    .axi4_m(m_if)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [1:0]  resp;
  } resp_t;

  int          chk = 0;
  int          err = 0;
  logic [31:0] exp_aw [$];
  logic [31:0] exp_w  [$];
  resp_t       exp_b  [$];
  resp_t       exp_r  [$];
  logic [1:0]  forbid = 2'b00;
  logic [1:0]  slv_bresp = 2'b00;

  function automatic resp_t mk(input int p, input logic [31:0] d, input logic [1:0] r);
    resp_t e;
    e.port = p; e.data = d; e.resp = r;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    chk++;
    err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // ---------------- upstream drivers ----------------
  task automatic set_aw(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin s_if[0].awvalid = v; s_if[0].awaddr = a; end
    else        begin s_if[1].awvalid = v; s_if[1].awaddr = a; end
  endtask

  task automatic set_w(input int p, input logic v, input logic [31:0] d);
    if (p == 0) begin s_if[0].wvalid = v; s_if[0].wdata = d; end
    else        begin s_if[1].wvalid = v; s_if[1].wdata = d; end
  endtask

  task automatic set_ar(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin s_if[0].arvalid = v; s_if[0].araddr = a; end
    else        begin s_if[1].arvalid = v; s_if[1].araddr = a; end
  endtask

  task automatic set_bready(input int p, input logic v);
    if (p == 0) s_if[0].bready = v; else s_if[1].bready = v;
  endtask

  task automatic set_rready(input int p, input logic v);
    if (p == 0) s_if[0].rready = v; else s_if[1].rready = v;
  endtask

  function automatic logic up_ready(input int p, input int ch);
    case (ch)
      0:       return (p == 0) ? s_if[0].awready : s_if[1].awready;
      1:       return (p == 0) ? s_if[0].wready  : s_if[1].wready;
      2:       return (p == 0) ? s_if[0].bvalid  : s_if[1].bvalid;
      3:       return (p == 0) ? s_if[0].arready : s_if[1].arready;
      default: return (p == 0) ? s_if[0].rvalid  : s_if[1].rvalid;
    endcase
  endfunction

  function automatic logic [14:0] outs();
    return {s_if[0].awready, s_if[0].wready, s_if[0].bvalid, s_if[0].arready, s_if[0].rvalid,
            s_if[1].awready, s_if[1].wready, s_if[1].bvalid, s_if[1].arready, s_if[1].rvalid,
            m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
  endfunction

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge aclk);
      #1;
    end
  endtask

  // Wait (bounded) until the port sees the ready/valid, then pass the edge.
  task automatic wait_up(input int p, input int ch, input string name);
    int t = 0;
    forever begin
      @(negedge aclk);
      if (up_ready(p, ch) === 1'b1) break;
      t++;
      if (t >= 60) begin fail_now({name, "_timeout"}); return; end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_m_w(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge aclk);
      if (m_if.wvalid && m_if.wready) begin ok = 1'b1; return; end
    end
    fail_now("m_w_timeout");
  endtask

  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d,
                    input int aw_gap, input int w_gap, input int b_hold);
    if (b_hold > 0) set_bready(p, 1'b0);
    fork
      begin step(aw_gap); set_aw(p, 1'b1, a); wait_up(p, 0, "awready"); set_aw(p, 1'b0, a); end
      begin step(w_gap);  set_w(p, 1'b1, d);  wait_up(p, 1, "wready");  set_w(p, 1'b0, d);  end
    join
    if (b_hold > 0) begin step(b_hold); set_bready(p, 1'b1); end
    wait_up(p, 2, "bvalid");
  endtask

  task automatic rd(input int p, input logic [31:0] a, input int r_hold);
    if (r_hold > 0) set_rready(p, 1'b0);
    set_ar(p, 1'b1, a);
    wait_up(p, 3, "arready");
    set_ar(p, 1'b0, a);
    if (r_hold > 0) begin step(r_hold); set_rready(p, 1'b1); end
    wait_up(p, 4, "rvalid");
  endtask

  // ---------------- downstream target model ----------------
  bit          n_aw, n_w, n_b, n_ar, n_r;
  logic [31:0] n_araddr;
  bit          got_aw, got_w;

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return (a == 32'h20) ? 32'h1234_5678 : {a[15:0], 16'hBEEF};
  endfunction

  always @(negedge aclk) begin
    n_aw     = m_if.awvalid && m_if.awready;
    n_w      = m_if.wvalid  && m_if.wready;
    n_b      = m_if.bvalid  && m_if.bready;
    n_ar     = m_if.arvalid && m_if.arready;
    n_r      = m_if.rvalid  && m_if.rready;
    n_araddr = m_if.araddr;
  end

  always @(posedge aclk) begin
    automatic logic rst = areset;
    #1;
    if (rst) begin
      m_if.bvalid = 1'b0; m_if.rvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0;
    end else begin
      if (n_b) begin m_if.bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; end
      if (n_aw) got_aw = 1'b1;
      if (n_w)  got_w  = 1'b1;
      if (got_aw && got_w && !m_if.bvalid) begin m_if.bvalid = 1'b1; m_if.bresp = slv_bresp; end
      if (n_r) m_if.rvalid = 1'b0;
      if (n_ar) begin m_if.rvalid = 1'b1; m_if.rdata = slv_data(n_araddr); m_if.rresp = 2'b00; end
    end
  end

  // ---------------- monitors ----------------
  task automatic b_mon(input int p, input logic [1:0] resp);
    resp_t e;
    if (exp_b.size() == 0) begin fail_now("b_extra"); return; end
    e = exp_b.pop_front();
    check("b_port", p, e.port);
    check("b_resp", resp, e.resp);
  endtask

  task automatic r_mon(input int p, input logic [31:0] d, input logic [1:0] resp);
    resp_t e;
    if (exp_r.size() == 0) begin fail_now("r_extra"); return; end
    e = exp_r.pop_front();
    check("r_port", p, e.port);
    check("r_data", d, e.data);
    check("r_resp", resp, e.resp);
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (m_if.awvalid && m_if.awready) begin
        if (exp_aw.size() == 0) fail_now("aw_extra");
        else check("aw_addr", m_if.awaddr, exp_aw.pop_front());
      end
      if (m_if.wvalid && m_if.wready) begin
        if (exp_w.size() == 0) fail_now("w_extra");
        else check("w_data", m_if.wdata, exp_w.pop_front());
      end
      if (s_if[0].bvalid && s_if[0].bready) b_mon(0, s_if[0].bresp);
      if (s_if[1].bvalid && s_if[1].bready) b_mon(1, s_if[1].bresp);
      if (s_if[0].rvalid && s_if[0].rready) r_mon(0, s_if[0].rdata, s_if[0].rresp);
      if (s_if[1].rvalid && s_if[1].rready) r_mon(1, s_if[1].rdata, s_if[1].rresp);
      if (forbid[0]) check("p0_quiet", {s_if[0].awready, s_if[0].wready, s_if[0].bvalid,
                                        s_if[0].arready, s_if[0].rvalid}, 0);
      if (forbid[1]) check("p1_quiet", {s_if[1].awready, s_if[1].wready, s_if[1].bvalid,
                                        s_if[1].arready, s_if[1].rvalid}, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    for (int k = 0; k < 2; k++) begin
      set_aw(k, 1'b0, 0); set_w(k, 1'b0, 0); set_ar(k, 1'b0, 0);
      set_bready(k, 1'b1); set_rready(k, 1'b1);
    end
    s_if[0].awid = '0; s_if[0].awprot = '0; s_if[0].wstrb = '1; s_if[0].arid = '0; s_if[0].arprot = '0;
    s_if[1].awid = '0; s_if[1].awprot = '0; s_if[1].wstrb = '1; s_if[1].arid = '0; s_if[1].arprot = '0;
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    m_if.bvalid = 1'b0; m_if.bresp = 2'b00; m_if.bid = '0;
    m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = 2'b00; m_if.rid = '0;

    areset = 1'b1;
    step(3);
    areset = 1'b0;
    @(negedge aclk);
    check("reset_quiet", outs(), 0);
    check("reset_wstate", dut.w_state, 0);
    check("reset_rstate", dut.r_state, 0);
    step(1);

    // Contended writes straight after reset: port 0 first, twice.
    exp_aw.push_back(32'h100); exp_w.push_back(32'h1111_0000); exp_b.push_back(mk(0, 0, 2'b00));
    exp_aw.push_back(32'h104); exp_w.push_back(32'h2222_0000); exp_b.push_back(mk(1, 0, 2'b00));
    fork
      wr(0, 32'h100, 32'h1111_0000, 0, 0, 0);
      wr(1, 32'h104, 32'h2222_0000, 0, 0, 0);
    join
    step(1);
    exp_aw.push_back(32'h108); exp_w.push_back(32'h3333_0000); exp_b.push_back(mk(0, 0, 2'b00));
    exp_aw.push_back(32'h10C); exp_w.push_back(32'h4444_0000); exp_b.push_back(mk(1, 0, 2'b00));
    fork
      wr(0, 32'h108, 32'h3333_0000, 0, 0, 0);
      wr(1, 32'h10C, 32'h4444_0000, 0, 0, 0);
    join
    step(1);

    // Single write, W one cycle after AW; port 1 must stay silent.
    exp_aw.push_back(32'h10); exp_w.push_back(32'hA5A5_A5A5); exp_b.push_back(mk(0, 0, 2'b00));
    forbid = 2'b10;
    wr(0, 32'h10, 32'hA5A5_A5A5, 0, 1, 0);
    forbid = 2'b00;
    step(1);

    // Concurrent write (port 0, SLVERR passed through) and read (port 1).
    slv_bresp = 2'b10;
    exp_aw.push_back(32'h200); exp_w.push_back(32'hCAFE_F00D); exp_b.push_back(mk(0, 0, 2'b10));
    exp_r.push_back(mk(1, 32'h1234_5678, 2'b00));
    fork
      wr(0, 32'h200, 32'hCAFE_F00D, 0, 0, 0);
      rd(1, 32'h20, 0);
      begin
        @(posedge aclk); @(negedge aclk);
        check("cc_wstate", dut.w_state, 1);
        check("cc_rstate", dut.r_state, 1);
        check("cc_wgnt", dut.w_gnt, 0);
        check("cc_rgnt", dut.r_gnt, 1);
      end
    join
    slv_bresp = 2'b00;
    step(1);

    // W accepted 3 cycles before AW.
    exp_aw.push_back(32'h300); exp_w.push_back(32'h5A5A_0001); exp_b.push_back(mk(0, 0, 2'b00));
    fork
      wr(0, 32'h300, 32'h5A5A_0001, 4, 0, 0);
      begin
        wait_m_w(ok);
        if (ok) begin
          repeat (3) begin
            @(negedge aclk);
            check("wfirst_state", dut.w_state, 1);
            check("wfirst_wvalid", m_if.wvalid, 0);
            check("wfirst_bvalid", s_if[0].bvalid, 0);
          end
          @(negedge aclk);
          check("wfirst_resp", dut.w_state, 2);
        end
      end
    join
    step(1);

    // AW and W accepted in the same cycle.
    exp_aw.push_back(32'h304); exp_w.push_back(32'h5A5A_0002); exp_b.push_back(mk(0, 0, 2'b00));
    fork
      wr(0, 32'h304, 32'h5A5A_0002, 0, 0, 0);
      begin
        wait_m_w(ok);
        if (ok) begin
          check("same_aw_hs", m_if.awvalid && m_if.awready, 1);
          @(negedge aclk);
          check("same_resp", dut.w_state, 2);
        end
      end
    join
    step(1);

    // B backpressure on port 0 while port 1 waits.
    exp_aw.push_back(32'h400); exp_w.push_back(32'h7777_0000); exp_b.push_back(mk(0, 0, 2'b00));
    exp_aw.push_back(32'h404); exp_w.push_back(32'h8888_0000); exp_b.push_back(mk(1, 0, 2'b00));
    fork
      wr(0, 32'h400, 32'h7777_0000, 0, 0, 5);
      begin step(2); wr(1, 32'h404, 32'h8888_0000, 0, 0, 0); end
      begin
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
          @(negedge aclk);
          if (dut.w_state == 2) ok = 1'b1;
        end
        if (!ok) fail_now("bp_resp_timeout");
        else repeat (5) begin
          check("bp_state", dut.w_state, 2);
          check("bp_gnt", dut.w_gnt, 0);
          check("bp_bvalid", s_if[0].bvalid, 1);
          check("bp_p1_ready", {s_if[1].awready, s_if[1].wready}, 0);
          @(negedge aclk);
        end
      end
    join
    step(1);

    // Reset in R_DATA with rvalid pending; the R must never reach port 0.
    set_rready(0, 1'b0);
    set_ar(0, 1'b1, 32'h500);
    wait_up(0, 3, "rst_arready");
    set_ar(0, 1'b0, 32'h500);
    wait_up(0, 4, "rst_rvalid");
    areset = 1'b1;
    step(1);
    areset = 1'b0;
    @(negedge aclk);
    check("rst_quiet", outs(), 0);
    check("rst_rstate", dut.r_state, 0);
    set_rready(0, 1'b1);
    step(1);

    // Contended reads after that reset: port 0 first.
    exp_r.push_back(mk(0, 32'h0030_BEEF, 2'b00));
    exp_r.push_back(mk(1, 32'h0040_BEEF, 2'b00));
    fork
      rd(0, 32'h30, 0);
      rd(1, 32'h40, 0);
    join
    step(3);

    check("aw_left", exp_aw.size(), 0);
    check("w_left", exp_w.size(), 0);
    check("b_left", exp_b.size(), 0);
    check("r_left", exp_r.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
